// File: rtl/or_reduce_flags.sv
// ---------------------------------------------------------------------------
// or_reduce_flags
// Purpose : reduction flags for a WIDTH-bit vector.
// Ports   :
//   i_vec  [WIDTH-1:0]  vector to reduce
//   o_any               1 when any bit of i_vec is set (reduction OR)
//   o_all               1 when every bit of i_vec is set (reduction AND)
// For WIDTH=1 both flags collapse to the single input bit.
// ---------------------------------------------------------------------------
module or_reduce_flags #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_any,
  output logic             o_all
);

  assign o_any = |i_vec;
  assign o_all = &i_vec;

endmodule

// File: rtl/basic_or.sv
// ---------------------------------------------------------------------------
// basic_or
// Purpose : bitwise OR of two operands with a combinational result, a
//           registered result with reduction flags, and a sticky OR
//           accumulator.
// Ports   :
//   clk        rising-edge clock for all registered outputs
//   rst_n      asynchronous active-low reset (clears every register)
//   a, b       [WIDTH-1:0] operands
//   in_valid   qualifies a/b for the registered path
//   acc_en     with in_valid, folds a|b into the accumulator
//   acc_clr    synchronous accumulator clear (dominates acc_en)
//   out        [WIDTH-1:0] combinational a|b, unaffected by clock/reset
//   out_q      [WIDTH-1:0] a|b captured on valid cycles, held otherwise
//   out_valid  in_valid delayed by one cycle
//   any_q      |(a|b) captured on valid cycles
//   all_q      &(a|b) captured on valid cycles
//   acc_q      [WIDTH-1:0] sticky accumulated OR
// Handshake: there is no backpressure. A cycle with in_valid=1 is one
// transaction; its registered result appears on out_q/any_q/all_q in the
// following cycle, flagged by out_valid=1. With out_valid=0 the registered
// result reflects the most recent valid transaction (or reset).
// ---------------------------------------------------------------------------
module basic_or #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             out_valid,
  output logic             any_q,
  output logic             all_q,
  output logic [WIDTH-1:0] acc_q
);

  logic [WIDTH-1:0] w_or;
  logic             w_any;
  logic             w_all;

  assign w_or = a | b;
  assign out  = w_or;

  or_reduce_flags #(
    .WIDTH (WIDTH)
  ) u_flags (
    .i_vec (w_or),
    .o_any (w_any),
    .o_all (w_all)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      any_q     <= 1'b0;
      all_q     <= 1'b0;
      acc_q     <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= w_or;
        any_q <= w_any;
        all_q <= w_all;
      end
      // Clear wins over accumulate; the current a|b is dropped in that case.
      if (acc_clr) begin
        acc_q <= '0;
      end else if (in_valid && acc_en) begin
        acc_q <= acc_q | w_or;
      end
    end
  end

endmodule

// File: tb/tb_basic_or.sv
module tb_basic_or;

  localparam int W = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  logic [W-1:0] a = '0, b = '0;
  logic         in_valid = 1'b0, acc_en = 1'b0, acc_clr = 1'b0;
  logic [W-1:0] out, out_q, acc_q;
  logic         out_valid, any_q, all_q;

  basic_or #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid),
    .acc_en(acc_en), .acc_clr(acc_clr), .out(out), .out_q(out_q),
    .out_valid(out_valid), .any_q(any_q), .all_q(all_q), .acc_q(acc_q)
  );

  // single-bit instance for the WIDTH=1 flag behaviour
  logic a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic out1, out_q1, out_valid1, any_q1, all_q1, acc_q1;

  basic_or #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .acc_en(1'b0), .acc_clr(1'b0), .out(out1), .out_q(out_q1),
    .out_valid(out_valid1), .any_q(any_q1), .all_q(all_q1), .acc_q(acc_q1)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard: {all, any, or} per valid transaction
  logic [W+1:0] exp_q[$];
  logic [W+1:0] exp_last = '0;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops on out_valid, otherwise checks the registered result holds
  initial begin
    logic [W+1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: out_valid=1 with empty queue at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_out_q", out_q, e[W-1:0]);
            chk("sb_any_q", {3'b0, any_q}, {3'b0, e[W]});
            chk("sb_all_q", {3'b0, all_q}, {3'b0, e[W+1]});
            exp_last = e;
          end
        end else begin
          chk("hold_out_q", out_q, exp_last[W-1:0]);
          chk("hold_any_q", {3'b0, any_q}, {3'b0, exp_last[W]});
          chk("hold_all_q", {3'b0, all_q}, {3'b0, exp_last[W+1]});
        end
      end
    end
  end

  // driver: one cycle of stimulus with hand-computed expectations
  task automatic step(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tv, input logic ten, input logic tclr,
                      input logic [W-1:0] e_or, input logic e_any,
                      input logic e_all, input logic [W-1:0] e_acc);
    @(negedge clk);
    a = ta; b = tb; in_valid = tv; acc_en = ten; acc_clr = tclr;
    #1;
    chk("out_comb", out, e_or);
    if (tv) exp_q.push_back({e_all, e_any, e_or});
    @(posedge clk);
    #1;
    chk("acc_q", acc_q, e_acc);
    chk("out_valid", {3'b0, out_valid}, {3'b0, tv});
  endtask

  initial begin
    // reset state, checked before any clock edge
    #1;
    chk("rst_out_q", out_q, 4'b0000);
    chk("rst_acc_q", acc_q, 4'b0000);
    chk("rst_flags", {1'b0, out_valid, any_q, all_q}, 4'b0000);
    @(negedge clk);
    #2 rst_n = 1'b1;

    //    a        b        v     en    clr   out      any   all   acc
    step(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b1101, 4'b0101, 1'b1, 1'b0, 1'b0, 4'b1101, 1'b1, 1'b0, 4'b0000);
    step(4'b1100, 4'b1110, 1'b1, 1'b0, 1'b0, 4'b1110, 1'b1, 1'b0, 4'b0000);
    step(4'b1100, 4'b0011, 1'b1, 1'b0, 1'b0, 4'b1111, 1'b1, 1'b1, 4'b0000);
    step(4'b1100, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b1100, 1'b1, 1'b0, 4'b0000);
    // accumulate, then clear
    step(4'b0001, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001);
    step(4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b0, 4'b0101);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0011, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 4'b0011);
    // clear beats simultaneous accumulate
    step(4'b1111, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, 1'b1, 4'b0000);
    // invalid cycles: out follows, registered result and acc hold
    step(4'b0101, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 4'b0000);
    step(4'b1000, 4'b0001, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 1'b0, 4'b0000);
    // sticky bits, including an all-zero valid input
    step(4'b1000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b0, 4'b1000);
    step(4'b0010, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 4'b1010);
    step(4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b1010);
    step(4'b0010, 4'b1000, 1'b1, 1'b1, 1'b0, 4'b1010, 1'b1, 1'b0, 4'b1010);

    // asynchronous reset between edges with acc_q=1010
    @(negedge clk);
    in_valid = 1'b0; acc_en = 1'b0;
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_acc_q", acc_q, 4'b0000);
    chk("async_rst_out_q", out_q, 4'b0000);
    chk("async_rst_valid", {3'b0, out_valid}, 4'b0000);
    chk("async_rst_flags", {2'b0, any_q, all_q}, 4'b0000);
    chk("async_rst_out", out, 4'b1010);
    exp_q.delete();
    exp_last = '0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // first capture after reset release
    step(4'b0110, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b0, 4'b0110);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0110);

    // WIDTH=1: any_q and all_q both equal the single result bit
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; v1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_flags_one", {2'b0, any_q1, all_q1}, 4'b0011);
    chk("w1_out_q_one", {3'b0, out_q1}, 4'b0001);
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_flags_zero", {2'b0, any_q1, all_q1}, 4'b0000);
    @(negedge clk);
    v1 = 1'b0;
    @(negedge clk);

    // every queued transaction must have been presented
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/basic_or.md
BASIC_OR -- requirements
Module: basic_or

Interface
REQ-001 Parameter WIDTH, default 8, operand and result bit width; SHALL support any WIDTH >= 1.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all registered outputs.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 a  input  WIDTH  operand A.
REQ-006 b  input  WIDTH  operand B.
REQ-007 in_valid  input  1  qualifies a/b for the registered path.
REQ-008 acc_en  input  1  when high with in_valid, folds a|b into the accumulator.
REQ-009 acc_clr  input  1  synchronous accumulator clear.
REQ-010 out  output  WIDTH  combinational bitwise OR of a and b.
REQ-011 out_q  output  WIDTH  registered a|b, captured on valid cycles.
REQ-012 out_valid  output  1  registered copy of in_valid.
REQ-013 any_q  output  1  registered reduction-OR of a|b.
REQ-014 all_q  output  1  registered reduction-AND of a|b.
REQ-015 acc_q  output  WIDTH  sticky accumulated OR.

Function
REQ-016 out SHALL equal a | b bit-for-bit with zero latency, independent of clk, rst_n and in_valid.
REQ-017 On a rising clk with in_valid=1, out_q SHALL load a|b, any_q SHALL load |(a|b), all_q SHALL load &(a|b).
REQ-018 With in_valid=0, out_q, any_q and all_q SHALL hold their values.
REQ-019 out_valid SHALL equal in_valid delayed by exactly one clk cycle.
REQ-020 On a rising clk: acc_clr=1 SHALL set acc_q to 0; otherwise in_valid=1 and acc_en=1 SHALL set acc_q to acc_q | a | b; otherwise acc_q SHALL hold.
REQ-021 With acc_clr=1, in_valid=1 and acc_en=1 together, clear SHALL win: acc_q becomes 0 and the current a|b is discarded.
REQ-022 Once set, an acc_q bit SHALL stay 1 until acc_clr or reset; there is no wrap or overflow.
REQ-023 For WIDTH=1, any_q and all_q SHALL both equal the single result bit.

Reset
REQ-024 While rst_n=0, out_q, acc_q, any_q, all_q and out_valid SHALL be 0 immediately, without waiting for clk.
REQ-025 rst_n SHALL be deasserted synchronously to clk by the integrator. The first capture SHALL occur on the first rising edge after deassertion.
REQ-026 Reset SHALL NOT affect the combinational out.
REQ-027 Reset asserted mid-accumulation SHALL discard acc_q contents.

Structure
REQ-028 No shared package SHALL be required. WIDTH is the only constant and stays a module parameter.
REQ-029 Reduction logic MAY be placed in one sub-module, or_reduce_flags, taking a WIDTH vector and producing any and all.
REQ-030 All registers SHALL sit in a single always block sensitive to posedge clk and negedge rst_n.

Verification
REQ-031 WIDTH=4, a=0000, b=0000 -> out=0000. After a valid edge: any_q=0, all_q=0.
REQ-032 WIDTH=4 sequence a/b = 1101/0101, 1100/1110, 1100/0011, 1100/1000 with 20-time-unit steps -> out = 1101, 1110, 1111, 1100. all_q=1 only after 1100/0011.
REQ-033 Accumulate with acc_en=1 and in_valid=1: 0001/0000 then 0000/0100 -> acc_q=0101. Then acc_clr=1 -> acc_q=0000 next edge.
REQ-034 Simultaneous acc_clr=1, acc_en=1, in_valid=1, a=1111 -> acc_q=0000.
REQ-035 in_valid=0 while a and b change -> out follows immediately, while out_q, any_q and all_q hold. out_valid=0 one cycle later.
REQ-036 Assert rst_n=0 between clock edges with acc_q=1010 -> acc_q, out_q and out_valid read 0 before the next edge. out is unchanged.
